// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: segment bit indices, the hex pattern table,
// and encode/decode helpers used by both the display driver and the sniffer.
package seven_seg_pkg;

  // Segment bit positions within a 7-bit pattern (a is the MSB).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Active-high pattern for each hex digit; entry i encodes nibble i.
  // Listed F down to 0 so the concatenation lands entry 0 in the low slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  // Decoder result: legal flag plus recovered nibble.
  typedef struct packed {
    logic       legal;
    logic [3:0] nib;
  } seg_dec_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

  // Reverse table lookup; legal stays 0 for any pattern not in the table.
  function automatic logic [3:0] seg_decode(input logic [6:0] pat, output logic legal);
    logic [3:0] n;
    n     = '0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        n     = 4'(i);
        legal = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment pattern -> {legal, nibble} decoder.
module seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output seg_dec_t   o_dec
);

  logic       w_legal;
  logic [3:0] w_nib;

  // Table lookup of the observed pattern.
  always_comb begin
    w_legal = 1'b0;
    w_nib   = seg_decode(i_pat, w_legal);
  end

  assign o_dec = '{legal: w_legal, nib: w_nib};

endmodule

// File: rtl/seven_segment_sniffer.sv
// Display-bus sniffer: synchronises segment/ground lines, waits for a stable
// observation window, decodes the pattern and rebuilds the 4-digit hex value.
// Optional build macro SEG_ACTIVE_LOW_EN: treat seg_i as active-low
// (common-anode board); it is inverted right after the synchroniser.
module seven_segment_sniffer
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_i,
  input  logic [3:0]  grounds_i,
  input  logic        clear_err_i,
  output logic [15:0] value_o,
  output logic [3:0]  digit_valid_o,
  output logic        update_o,
  output logic        error_o
);

  localparam int NUM_DIGITS = 4;
  localparam int CW         = $clog2(STABLE_CYCLES + 1);

  logic [10:0]                 r_sync1, r_sync2, r_prev;
  logic [CW-1:0]               r_cnt;
  logic [NUM_DIGITS-1:0][3:0]  r_val;
  logic [NUM_DIGITS-1:0]       r_vld;
  logic                        r_upd, r_err;

  logic [6:0]            w_seg;
  logic [10:0]           w_obs;
  logic                  w_same, w_fire, w_set_err;
  logic [NUM_DIGITS-1:0] w_wr;
  seg_dec_t              w_dec;

  // Two-flop synchroniser on the raw {grounds, seg} word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {grounds_i, seg_i};
      r_sync2 <= r_sync1;
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign w_seg = ~r_sync2[6:0];
`else
  assign w_seg = r_sync2[6:0];
`endif

  assign w_obs  = {r_sync2[10:7], w_seg};
  assign w_same = (w_obs == r_prev);
  // Fire on the single cycle the counter steps into STABLE_CYCLES.
  assign w_fire = w_same && (r_cnt == CW'(STABLE_CYCLES - 1));

  // Stability counter: reload on any change, saturate once stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_obs;
      if (!w_same)
        r_cnt <= CW'(1);
      else if (r_cnt != CW'(STABLE_CYCLES))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  seg_pattern_decode u_dec (
    .i_pat (w_seg),
    .o_dec (w_dec)
  );

  // Digit select: ~grounds is one-hot for a scanned digit and all-ones in
  // static mode, so it doubles as the write mask. Overlap/blank is ignored.
  always_comb begin
    w_wr      = '0;
    w_set_err = 1'b0;
    if (w_fire) begin
      case (w_obs[10:7])
        4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000: begin
          if (w_dec.legal) w_wr      = ~w_obs[10:7];
          else             w_set_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output registers: nibble writes, valid flags and the update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      r_vld <= '0;
      r_upd <= 1'b0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (w_wr[d]) begin
          r_val[d] <= w_dec.nib;
          r_vld[d] <= 1'b1;
        end
      end
      r_upd <= |w_wr;
    end
  end

  // Sticky error; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_err <= 1'b0;
    else if (w_set_err)   r_err <= 1'b1;
    else if (clear_err_i) r_err <= 1'b0;
  end

  assign value_o       = r_val;
  assign digit_valid_o = r_vld;
  assign update_o      = r_upd;
  assign error_o       = r_err;

endmodule
